// File: rtl/l2_conv_mac.sv
// ----------------------------------------------------------------------------
// l2_conv_mac
//
// Layer-2 convolution MAC. Sits at the read end of the layer-1 pooled-feature
// buffer: when the window sequencer offers a window (win_rdy) it captures nine
// consecutive sample pairs (one 3x3 window per channel), accumulates the
// dual-channel 9-tap weighted sum, scales by FRAC_BITS, saturates to 18 bits
// and hands the result downstream over a valid/ready handshake. Accepted
// results are counted per frame and layer_done pulses on the NUM_WIN-th one.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_done             synchronous frame clear (drops any in-flight result)
//   win_rdy / bsy       window offer from the producer / consumer busy
//   din_0, din_1        signed 18-bit channel samples, one pair per CAP cycle
//   wt_wr/addr/data     weight write port (0-8 ch0 taps, 9-17 ch1 taps)
//   out_vld/rdy/data    result handshake, signed 18-bit saturated result
//   win_cnt             results accepted this frame
//   layer_done          one-cycle pulse on acceptance of the final window
//
// Build option
//   L2_CONV_RELU_EN     when defined, negative saturated results become 0.
// ----------------------------------------------------------------------------
module l2_conv_mac #(
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 42,
    parameter int unsigned NUM_WIN   = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_done,
    input  logic        win_rdy,
    output logic        bsy,
    input  logic [17:0] din_0,
    input  logic [17:0] din_1,
    input  logic        wt_wr,
    input  logic [4:0]  wt_addr,
    input  logic [17:0] wt_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [17:0] out_data,
    output logic [7:0]  win_cnt,
    output logic        layer_done
);

    typedef enum logic [1:0] {StIdle, StCap, StSat, StOut} state_e;

    localparam logic signed [ACC_W-1:0] SatMax    = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] SatMin    = ACC_W'(-131072);
    localparam logic [7:0]              NumWinCnt = 8'(NUM_WIN);

    state_e                  state_q, state_d;
    logic [3:0]              tap_q, tap_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [17:0]             out_data_q, out_data_d;
    logic                    out_vld_q, out_vld_d;
    logic                    bsy_q, bsy_d;
    logic [7:0]              win_cnt_q, win_cnt_d;
    logic                    layer_done_q, layer_done_d;
    logic [17:0]             wt_q [18];

    // Weights are host-owned state and deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (wt_wr && (wt_addr < 5'd18)) begin
            wt_q[wt_addr] <= wt_data;
        end
    end

    // MAC datapath: operands sign-extended to the accumulator width so the
    // products and the running sum are exact.
    logic [4:0]              idx0, idx1;
    logic signed [ACC_W-1:0] d0_ext, d1_ext, w0_ext, w1_ext, mac_sum;

    always_comb begin
        idx0    = {1'b0, tap_q};
        idx1    = idx0 + 5'd9;
        d0_ext  = {{(ACC_W-18){din_0[17]}}, din_0};
        d1_ext  = {{(ACC_W-18){din_1[17]}}, din_1};
        w0_ext  = {{(ACC_W-18){wt_q[idx0][17]}}, wt_q[idx0]};
        w1_ext  = {{(ACC_W-18){wt_q[idx1][17]}}, wt_q[idx1]};
        mac_sum = acc_q + d0_ext * w0_ext + d1_ext * w1_ext;
    end

    // Scale and saturate.
    logic signed [ACC_W-1:0] shifted;
    logic [17:0]             sat_val;

    always_comb begin
        shifted = acc_q >>> FRAC_BITS;
        if (shifted > SatMax) begin
            sat_val = 18'h1FFFF;
        end else if (shifted < SatMin) begin
            sat_val = 18'h20000;
        end else begin
            sat_val = shifted[17:0];
        end
`ifdef L2_CONV_RELU_EN
        if (sat_val[17]) begin
            sat_val = '0;
        end
`endif
    end

    logic [7:0] win_cnt_inc;
    assign win_cnt_inc = win_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_vld_d    = out_vld_q;
        win_cnt_d    = win_cnt_q;
        layer_done_d = 1'b0;

        if (tx_done) begin
            state_d   = StIdle;
            tap_d     = '0;
            acc_d     = '0;
            win_cnt_d = '0;
            out_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_rdy) begin
                        state_d = StCap;
                        tap_d   = '0;
                        acc_d   = '0;
                    end
                end
                StCap: begin
                    acc_d = mac_sum;
                    if (tap_q == 4'd8) begin
                        tap_d   = '0;
                        state_d = StSat;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end
                StSat: begin
                    out_data_d = sat_val;
                    out_vld_d  = 1'b1;
                    state_d    = StOut;
                end
                StOut: begin
                    if (out_rdy) begin
                        out_vld_d = 1'b0;
                        state_d   = StIdle;
                        if (win_cnt_inc == NumWinCnt) begin
                            win_cnt_d    = '0;
                            layer_done_d = 1'b1;
                        end else begin
                            win_cnt_d = win_cnt_inc;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Registered busy: high from the first CAP cycle until back in IDLE.
        bsy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tap_q        <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_vld_q    <= 1'b0;
            bsy_q        <= 1'b0;
            win_cnt_q    <= '0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_vld_q    <= out_vld_d;
            bsy_q        <= bsy_d;
            win_cnt_q    <= win_cnt_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign bsy        = bsy_q;
    assign out_vld    = out_vld_q;
    assign out_data   = out_data_q;
    assign win_cnt    = win_cnt_q;
    assign layer_done = layer_done_q;

endmodule

// File: doc/l2_conv_mac.md
Name: l2_conv_mac

Overview:
- Consumer at the read end of the layer-1 pooled-feature buffer.
- Handshakes with the buffer's window sequencer using win_rdy/bsy, then captures one 3x3 window per channel as 9 sequential sample pairs.
- Computes a dual-channel 9-tap weighted sum, scales and saturates it, and presents one 18-bit result per window to the next layer over a valid/ready handshake.
- Counts windows and flags layer completion.

Parameters:
FRAC_BITS, 8, fractional bits of the weights (Q-format); the accumulator is arithmetically right-shifted by this amount.
ACC_W, 42, accumulator width in bits (>= 41 required).
NUM_WIN, 100, windows per frame; layer_done fires on acceptance of the NUM_WIN-th result.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tx_done  in  1  synchronous frame clear
win_rdy  in  1  producer has a complete window available
bsy  out  1  consumer busy; producer must not start a window while high
din_0  in  18  signed channel-0 sample
din_1  in  18  signed channel-1 sample
wt_wr  in  1  weight write strobe
wt_addr  in  5  weight index: 0-8 = channel-0 taps 0-8; 9-17 = channel-1 taps 0-8; 18-31 ignored
wt_data  in  18  signed weight, Q(17-FRAC_BITS).FRAC_BITS
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts result
out_data  out  18  signed saturated result
win_cnt  out  8  results accepted this frame
layer_done  out  1  one-cycle pulse on acceptance of the final window

Behaviour:
- Clock/reset: clk; reset rst_n, asynchronous, active-low. Reset values: bsy=0, out_vld=0, out_data=0, win_cnt=0, layer_done=0, accumulator=0, state=IDLE. Weights are not reset; writing them is the host's job.
- Weight port:
  - wt_wr writes wt_data to weight[wt_addr] at the clock edge, in any state.
  - A write to a tap during CAP takes effect for later taps only.
- State machine IDLE -> CAP -> SAT -> OUT:
  - IDLE: bsy=0. If win_rdy=1, go to CAP with tap=0 and acc=0. The producer issues its first read in this same cycle (cycle T).
  - CAP (cycles T+1..T+9): bsy=1. Each cycle, acc += din_0*w[tap] + din_1*w[9+tap], full-width signed arithmetic, then tap++. After tap 8 go to SAT. No per-sample handshake; exactly 9 consecutive samples are consumed.
  - SAT (T+10): bsy=1. r = acc >>> FRAC_BITS, clamped to [-131072, 131071]. Register r into out_data, set out_vld=1, go to OUT.
  - OUT: bsy=1 and out_vld=1; out_data held stable. When out_rdy=1: out_vld=0, win_cnt++, go to IDLE. If the new win_cnt equals NUM_WIN, also pulse layer_done for that one cycle and set win_cnt to 0.
- Timing guarantee: bsy is high from T+1. The producer's return check at T+10 therefore sees bsy=1 and cannot overlap a new window.
- Latency: first out_vld at T+11; minimum window period 12 cycles (out_rdy tied high).
- tx_done (synchronous, highest priority below reset):
  - Next state IDLE; acc, tap, win_cnt, out_vld, layer_done cleared; weights kept.
  - Mid-CAP or mid-OUT: the in-flight result is discarded, with no out_vld pulse.
- win_rdy is ignored outside IDLE.
- Simultaneous out_rdy and tx_done: tx_done wins; the result is not counted.

Optional Feature:
- Macro L2_CONV_RELU_EN.
- Defined: SAT applies ReLU after clamping; negative r becomes 0.
- Undefined: signed saturated value passes through unchanged.

Test Plan:
- All weights 256 (1.0); din_0 = 1..9 over CAP; din_1 = 0; out_rdy=1 -> out_vld at T+11 with out_data=45; bsy high T+1..T+11.
- All weights 256; din_0 = din_1 = 131071 for 9 cycles -> out_data=131071 (clamped). With inputs -131072 -> -131072 without macro, 0 with L2_CONV_RELU_EN.
- din_0 = -5 x9, w0=256, din_1 = 0 -> out_data = -45 without macro; 0 with L2_CONV_RELU_EN.
- out_rdy low for 5 cycles, win_rdy held high -> out_data stable, bsy=1, no new CAP entry; accepted on out_rdy=1, win_cnt=1.
- tx_done asserted at T+4 -> IDLE at T+5, no out_vld, win_cnt=0. Next window computes correctly with the weights retained.
- NUM_WIN=4, four windows back-to-back -> layer_done single pulse on 4th acceptance, win_cnt returns to 0.
